if_prefetch_unit: RTL

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to the instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch queue, and each queued instruction is presented to IF/ID with its PC and PC+4. It honours stalls from hazard detection and flushes on branch/jump redirects.

---
 rtl/if_prefetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// requests and buffers returned instructions in a small prefetch queue.
module if_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [31:0]                instr_pc_p4,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_n;

    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   addr_q, addr_n;
    logic          drop, drop_n;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          acked;
    logic          push;
    logic          pop;
    logic          issue;
    logic          can_issue;
    logic [CW-1:0] occ_next;
    logic [31:0]   base_pc;

    assign acked = (state == WAIT) && imem_ack;
    assign push  = acked && !drop && !redirect;
    assign pop   = instr_valid && !stall && !redirect;

    // Occupancy after this edge; a new request needs one more free slot.
    assign occ_next  = redirect ? '0 : count + CW'(push) - CW'(pop);
    assign can_issue = occ_next < CW'(DEPTH);
    assign base_pc   = redirect ? {redirect_pc[31:2], 2'b00} : fetch_pc;

    always_comb begin
        state_n    = state;
        fetch_pc_n = base_pc;
        addr_n     = addr_q;
        drop_n     = drop;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                issue = can_issue;
            end
            WAIT: begin
                if (imem_ack) begin
                    issue  = can_issue;
                    drop_n = 1'b0;
                end else if (redirect) begin
                    drop_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (issue) begin
            state_n    = WAIT;
            addr_n     = base_pc;
            fetch_pc_n = base_pc + 32'd4;
        end else if (acked) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            addr_q   <= addr_n;
            drop     <= drop_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= addr_q;
        end
    end

    assign imem_req    = (state == WAIT);
    assign imem_addr   = addr_q;
    assign q_count     = count;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_instr[head] : 32'h0;
    assign instr_pc    = instr_valid ? q_pc[head] : 32'h0;
    assign instr_pc_p4 = instr_valid ? q_pc[head] + 32'd4 : 32'h0;

endmodule
